// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned memory reads, buffers up to
// two returned words with their PCs, and squashes in-flight reads on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  instr_op,
    output logic [5:0]  instr_funct,
    output logic [3:0]  instr_rd
);

    // state   | meaning
    // RUN     | normal fetch; fetch_pc is the next address to request
    // DISCARD | old request still outstanding on hold_addr; its data is dropped

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] hold_addr;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic [31:0] target;

    // Request is gated by reset_n so it drops combinationally while reset is held.
    assign imem_req    = reset_n && ((state == RUN && count < 2'd2) || state == DISCARD);
    assign imem_addr   = (state == DISCARD) ? hold_addr : fetch_pc;

    assign instr_valid = (count != 2'd0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign instr_op    = instr[27:26];
    assign instr_funct = instr[25:20];
    assign instr_rd    = instr[15:12];

    assign target = redirect_pc & 32'hFFFF_FFFC;
    assign push   = (state == RUN) && imem_req && imem_ack && !redirect;
    assign pop    = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            hold_addr <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= fetch_pc;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end

            case (state)
                RUN: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        if (imem_req && !imem_ack) begin
                            hold_addr <= fetch_pc;
                            state     <= DISCARD;
                        end
                    end else if (imem_req && imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    if (imem_ack) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (word aligned).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction memory read request.
REQ-005 SHALL have port imem_addr  output  32  request address, bits [1:0] always 0.
REQ-006 SHALL have port imem_ack  input  1  memory completes the request this cycle.
REQ-007 SHALL have port imem_rdata  input  32  read data, valid only when imem_req and imem_ack are both 1.
REQ-008 SHALL have port redirect  input  1  taken branch or PC write from execute (PCS path).
REQ-009 SHALL have port redirect_pc  input  32  new fetch target; bits [1:0] ignored and treated as 00.
REQ-010 SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port instr_ready  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port instr  output  32  head instruction word.
REQ-013 SHALL have port instr_pc  output  32  address of the head instruction.
REQ-014 SHALL have ports instr_op[1:0], instr_funct[5:0], instr_rd[3:0]  output  combinational slices instr[27:26], instr[25:20], instr[15:12] for the decoder.

Function
REQ-015 SHALL hold a 2-entry FIFO of {instr, pc}; instr_valid = (count != 0); head pops when instr_valid and instr_ready are both 1.
REQ-016 SHALL keep fetch_pc (next address to request) and a 2-state FSM: RUN and DISCARD.
REQ-017 SHALL drive imem_req = (RUN and count < 2) or DISCARD, with imem_addr = fetch_pc in RUN and the held old address in DISCARD.
REQ-018 SHALL keep imem_req high with imem_addr stable from assertion until the cycle imem_ack = 1; a request is never withdrawn.
REQ-019 In RUN, on req & ack without redirect, SHALL push {imem_rdata, fetch_pc} and set fetch_pc = fetch_pc + 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-020 SHALL accept push and pop in the same cycle; count is unchanged and order is preserved.
REQ-021 SHALL never push into a full FIFO; REQ-017 guarantees this, and an ack seen with imem_req = 0 SHALL be ignored.
REQ-022 On redirect in any state, SHALL flush the FIFO (count = 0 next cycle); flush overrides a same-cycle pop and push.
REQ-023 On redirect in RUN with imem_req = 0, or with req & ack in the same cycle, SHALL drop any returned data, set fetch_pc = {redirect_pc[31:2], 2'b00}, and stay in RUN.
REQ-024 On redirect in RUN with req = 1 and ack = 0, SHALL latch the target into fetch_pc, hold the old address on imem_addr, and go to DISCARD.
REQ-025 In DISCARD, SHALL drop data on ack and go to RUN; fetch_pc is not incremented.
REQ-026 A further redirect during DISCARD SHALL overwrite the latched target; a redirect with ack in the same cycle SHALL use the new target.
REQ-027 SHALL not set instr_valid from any data returned in DISCARD.
REQ-028 Latency with a zero-wait memory SHALL be: request cycle N, instr_valid = 1 in cycle N+1; sustained throughput SHALL be 1 instruction/cycle with instr_ready held 1.

Reset
REQ-029 While reset_n = 0, SHALL force imem_req = 0, instr_valid = 0, count = 0, state = RUN, fetch_pc = RESET_PC, and FIFO pc/instr = 0, asynchronously.
REQ-030 SHALL assert imem_req with imem_addr = RESET_PC in the first cycle after reset_n rises.
REQ-031 Reset asserted mid-request SHALL abandon the request; the memory SHALL treat reset as cancelling its transaction.

Verification
REQ-032 SHALL cover: reset release, ack tied 1, ready = 1 -> instr_pc sequence 0, 4, 8, ..., one per cycle, instr_valid first high in cycle 2.
REQ-033 SHALL cover: ready = 0 for 5 cycles, ack tied 1 -> exactly 2 entries (pc 0, 4), imem_req low, no further requests; ready = 1 -> pc 0, 4, 8 in order.
REQ-034 SHALL cover: request to 0x10 pending, ack 3 cycles late, redirect to 0x103 in cycle 1 -> DISCARD, old data dropped, next request addr 0x100, first valid instr_pc = 0x100.
REQ-035 SHALL cover: redirect to 0x40 with ack and pop in the same cycle -> FIFO empty next cycle, that data dropped, next imem_addr = 0x40.
REQ-036 SHALL cover: redirect to 0xFFFF_FFFC, ack tied 1 -> instr_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-037 SHALL cover: reset_n pulsed low mid-request with FIFO full -> instr_valid and imem_req drop immediately; after release, imem_addr = RESET_PC.
